// File: rtl/corefifo_wr_ctrl.sv
// Write-side controller of an asynchronous FIFO: binary/Gray write pointer,
// two-stage read-pointer synchroniser, fill level and full/almost-full flags.
module corefifo_wr_ctrl #(
    parameter int ADDRWIDTH    = 3,
    parameter int AFULL_THRESH = 6
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 we,
    input  logic [ADDRWIDTH:0]   rd_ptr_gray_async,
    output logic                 mem_we,
    output logic [ADDRWIDTH-1:0] mem_waddr,
    output logic [ADDRWIDTH:0]   wr_ptr_gray,
    output logic                 full,
    output logic                 afull,
    output logic [ADDRWIDTH:0]   wr_count,
    output logic                 overflow
);

    localparam int PW = ADDRWIDTH + 1;
    localparam logic [PW-1:0] DEPTH_C = {1'b1, {ADDRWIDTH{1'b0}}};
    localparam logic [PW-1:0] AFULL_C = PW'(AFULL_THRESH);

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [PW-1:0] sync1_q, sync2_q;
    logic [PW-1:0] wp_bin_q, wp_bin_d;
    logic [PW-1:0] wp_gray_q, wp_gray_d;
    logic [PW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          afull_q, afull_d;
    logic          overflow_q, overflow_d;
    logic [PW-1:0] rp_bin_s;
    logic          accept_s;

    // Next-state: pointer advance, fill level against the synchronised read pointer, flags
    always_comb begin
        rp_bin_s   = gray2bin(sync2_q);
        accept_s   = we & ~full_q;
        wp_bin_d   = wp_bin_q + {{ADDRWIDTH{1'b0}}, accept_s};
        wp_gray_d  = bin2gray(wp_bin_d);
        count_d    = wp_bin_d - rp_bin_s;
        full_d     = (count_d == DEPTH_C);
        afull_d    = (count_d >= AFULL_C);
        overflow_d = we & full_q;
    end

    // Two-flop synchroniser for the read-domain Gray pointer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q <= {PW{1'b0}};
            sync2_q <= {PW{1'b0}};
        end else begin
            sync1_q <= rd_ptr_gray_async;
            sync2_q <= sync1_q;
        end
    end

    // Write pointer, fill level and flag registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wp_bin_q   <= {PW{1'b0}};
            wp_gray_q  <= {PW{1'b0}};
            count_q    <= {PW{1'b0}};
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wp_bin_q   <= wp_bin_d;
            wp_gray_q  <= wp_gray_d;
            count_q    <= count_d;
            full_q     <= full_d;
            afull_q    <= afull_d;
            overflow_q <= overflow_d;
        end
    end

    // The strobe is gated by rstn because full alone reads 0 during reset
    assign mem_we      = we & ~full_q & rstn;
    assign mem_waddr   = wp_bin_q[ADDRWIDTH-1:0];
    assign wr_ptr_gray = wp_gray_q;
    assign full        = full_q;
    assign afull       = afull_q;
    assign wr_count    = count_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_corefifo_wr_ctrl.sv
// Directed bench for corefifo_wr_ctrl (ADDRWIDTH=3, AFULL_THRESH=6).
module tb_corefifo_wr_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic       we;
    logic [3:0] rd_ptr_gray_async;
    logic       mem_we;
    logic [2:0] mem_waddr;
    logic [3:0] wr_ptr_gray;
    logic       full;
    logic       afull;
    logic [3:0] wr_count;
    logic       overflow;

    int n_total = 0;
    int n_bad   = 0;

    logic [4:0] rb;
    logic [3:0] m_wp, m_s1, m_s2, m_cnt;

    corefifo_wr_ctrl #(.ADDRWIDTH(3), .AFULL_THRESH(6)) dut (
        .clk               (clk),
        .rstn              (rstn),
        .we                (we),
        .rd_ptr_gray_async (rd_ptr_gray_async),
        .mem_we            (mem_we),
        .mem_waddr         (mem_waddr),
        .wr_ptr_gray       (wr_ptr_gray),
        .full              (full),
        .afull             (afull),
        .wr_count          (wr_count),
        .overflow          (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] b2g(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [3:0] g2b(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        b[2] = b[3] ^ g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_we"},  {31'd0, mem_we},   32'd0);
        chk({tag, "_waddr"},   {29'd0, mem_waddr}, 32'd0);
        chk({tag, "_gray"},    {28'd0, wr_ptr_gray}, 32'd0);
        chk({tag, "_full"},    {31'd0, full},     32'd0);
        chk({tag, "_afull"},   {31'd0, afull},    32'd0);
        chk({tag, "_cnt"},     {28'd0, wr_count}, 32'd0);
        chk({tag, "_ovf"},     {31'd0, overflow}, 32'd0);
    endtask

    task automatic do_reset;
        rstn = 1'b0;
        we = 1'b0;
        rd_ptr_gray_async = 4'd0;
        tick;
        tick;
        chk_all_zero("rst");
        @(negedge clk);
        rstn = 1'b1;
        tick;
    endtask

    initial begin
        rstn = 1'b0;
        we = 1'b0;
        rd_ptr_gray_async = 4'd0;
        rb = 5'd0;
        do_reset;

        // Fill from empty
        for (int i = 0; i < 8; i++) begin
            we = 1'b1;
            #1;
            chk("fill_waddr", {29'd0, mem_waddr}, i);
            chk("fill_mem_we", {31'd0, mem_we}, 32'd1);
            tick;
            chk("fill_cnt", {28'd0, wr_count}, i + 1);
            chk("fill_afull", {31'd0, afull}, {31'd0, (i + 1 >= 6)});
            chk("fill_full", {31'd0, full}, {31'd0, (i + 1 == 8)});
        end
        chk("fill_gray", {28'd0, wr_ptr_gray}, 32'hC);

        // Overflow while full
        for (int i = 0; i < 2; i++) begin
            we = 1'b1;
            #1;
            chk("ovf_mem_we", {31'd0, mem_we}, 32'd0);
            tick;
            chk("ovf_pulse", {31'd0, overflow}, 32'd1);
            chk("ovf_gray", {28'd0, wr_ptr_gray}, 32'hC);
            chk("ovf_cnt", {28'd0, wr_count}, 32'd8);
        end
        we = 1'b0;
        tick;
        chk("ovf_end", {31'd0, overflow}, 32'd0);
        chk("ovf_full", {31'd0, full}, 32'd1);

        // Drain release: full drops on the third edge
        rd_ptr_gray_async = 4'b0001;
        tick;
        chk("drain_e1", {31'd0, full}, 32'd1);
        tick;
        chk("drain_e2", {31'd0, full}, 32'd1);
        tick;
        chk("drain_e3", {31'd0, full}, 32'd0);
        chk("drain_cnt", {28'd0, wr_count}, 32'd7);
        chk("drain_afull", {31'd0, afull}, 32'd1);

        // Wrap: 20 writes with reads trailing
        do_reset;
        rb = 5'd0;
        m_wp = 4'd0;
        m_s1 = 4'd0;
        m_s2 = 4'd0;
        for (int i = 0; i < 20; i++) begin
            we = 1'b1;
            if (i >= 3) rb = rb + 5'd1;
            rd_ptr_gray_async = b2g(rb[3:0]);
            #1;
            m_wp  = m_wp + 4'd1;
            m_cnt = m_wp - g2b(m_s2);
            m_s2  = m_s1;
            m_s1  = rd_ptr_gray_async;
            tick;
            chk("wrap_cnt", {28'd0, wr_count}, {28'd0, m_cnt});
            chk("wrap_full", {31'd0, full}, 32'd0);
        end
        we = 1'b0;
        #1;
        chk("wrap_waddr", {29'd0, mem_waddr}, 32'd4);
        chk("wrap_gray", {28'd0, wr_ptr_gray}, 32'h6);
        for (int i = 0; i < 4; i++) tick;
        chk("wrap_settle", {28'd0, wr_count}, 32'd3);

        // Simultaneous write and synchronised read advance at count 5
        we = 1'b1;
        tick;
        tick;
        we = 1'b0;
        chk("sim_pre", {28'd0, wr_count}, 32'd5);
        rb = 5'd18;
        rd_ptr_gray_async = b2g(rb[3:0]);
        tick;
        chk("sim_s1", {28'd0, wr_count}, 32'd5);
        tick;
        chk("sim_s2", {28'd0, wr_count}, 32'd5);
        we = 1'b1;
        tick;
        we = 1'b0;
        chk("sim_cnt", {28'd0, wr_count}, 32'd5);
        chk("sim_afull", {31'd0, afull}, 32'd0);
        tick;
        chk("sim_post", {28'd0, wr_count}, 32'd5);

        // Reset mid-operation at count 4
        rb = 5'd19;
        rd_ptr_gray_async = b2g(rb[3:0]);
        tick;
        tick;
        tick;
        chk("mid_cnt", {28'd0, wr_count}, 32'd4);
        we = 1'b1;
        #2;
        rstn = 1'b0;
        #1;
        chk_all_zero("async_rst");
        rd_ptr_gray_async = 4'd0;
        tick;
        tick;
        chk("rst_hold_mem_we", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("post_rst_waddr", {29'd0, mem_waddr}, 32'd0);
        chk("post_rst_mem_we", {31'd0, mem_we}, 32'd1);
        tick;
        we = 1'b0;
        chk("post_rst_cnt", {28'd0, wr_count}, 32'd1);
        chk("post_rst_waddr1", {29'd0, mem_waddr}, 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
